wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the writeback stage fused with the 32-entry architectural register file.
- Takes the MEM/WB register outputs and selects the writeback data (memory, ALU or link address).
- Commits the selected data to the destination register on the clock edge.
- Serves the two ID-stage read ports, with same-cycle write-through bypass.
- Exposes the selected writeback data for the forwarding unit, plus registered debug state (last write, write count).

Parameters:
DATA_WIDTH, 32, register and datapath width
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
COUNT_WIDTH, 32, width of the effective-write counter

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous active-high reset
RegWrite_In  in  1  MEM/WB write enable
MemToReg_In  in  1  1 = write DM_ReadData_In, 0 = write ALU_Result_In
Link_In  in  1  1 = write PC_AddResult_In (jal/jalr); overrides MemToReg_In
DM_ReadData_In  in  DATA_WIDTH  data memory load result
ALU_Result_In  in  DATA_WIDTH  ALU result
PC_AddResult_In  in  DATA_WIDTH  link address
MEM_WB_Rd_In  in  ADDR_WIDTH  destination register index
ReadReg1  in  ADDR_WIDTH  read port 1 index
ReadReg2  in  ADDR_WIDTH  read port 2 index
ReadData1  out  DATA_WIDTH  read port 1 data, combinational
ReadData2  out  DATA_WIDTH  read port 2 data, combinational
WriteData_Out  out  DATA_WIDTH  selected writeback data, combinational, for forwarding
LastWriteReg  out  ADDR_WIDTH  index of most recent effective write, registered
LastWriteData  out  DATA_WIDTH  data of most recent effective write, registered
WriteCount  out  COUNT_WIDTH  number of effective writes since reset, registered

Behaviour:
- Reset:
  - Rst high clears regs[0..31], LastWriteReg, LastWriteData and WriteCount to 0 immediately, without waiting for a clock edge.
  - While Rst is high, no writes occur.
  - Rst assertion mid-stream discards any pending write in that cycle.
  - First write is possible on the first rising edge after Rst deasserts.
- Writeback select, combinational, priority order:
  - Link_In=1 -> PC_AddResult_In.
  - Else MemToReg_In=1 -> DM_ReadData_In.
  - Else -> ALU_Result_In.
  - WriteData_Out always reflects this selection, regardless of RegWrite_In.
- Effective write: RegWrite_In=1 and MEM_WB_Rd_In!=0.
  - On the rising edge: regs[Rd] <= WriteData_Out, LastWriteReg <= Rd, LastWriteData <= WriteData_Out, WriteCount <= WriteCount+1.
  - WriteCount wraps modulo 2**COUNT_WIDTH.
- Register 0:
  - Hardwired zero.
  - A write with Rd=0 is discarded: no state changes, no count.
  - Reads of index 0 always return 0, even while a write to 0 is in flight.
- Read ports, combinational:
  - ReadDataN = WriteData_Out when an effective write is in progress and MEM_WB_Rd_In==ReadRegN (write-through bypass, so no half-cycle split is needed).
  - Otherwise ReadDataN = regs[ReadRegN].
  - Both ports may hit the same register or the same bypass simultaneously; both return identical data.
- Latency: write data is visible combinationally on the read ports in the write cycle and stored from the next edge onward. Debug outputs update one edge after the write.
- RegWrite_In=0: no state changes, whatever Link_In or MemToReg_In are set to.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset value: assert Rst asynchronously between edges -> ReadData1/2 = 0 for every index, WriteCount=0, LastWriteReg=0, with no clock edge required.
2. ALU write then read:
   - Stimulus: RegWrite=1, MemToReg=0, Link=0, ALU=0x0000_1234, Rd=8, ReadReg1=8.
   - Same cycle: ReadData1=0x1234 via bypass.
   - After the edge, with RegWrite=0: ReadData1=0x1234 from storage, LastWriteReg=8, WriteCount=1.
3. Select priority:
   - Stimulus: DM=0xAAAA_AAAA, ALU=0x5555_5555, PC=0x0040_0008.
   - MemToReg=1, Link=0 -> Rd=9 gets 0xAAAA_AAAA.
   - MemToReg=1, Link=1, Rd=31 -> $31 gets 0x0040_0008.
   - MemToReg=0, Link=0 -> Rd=10 gets 0x5555_5555.
4. $zero protection: RegWrite=1, Rd=0, ALU=0xDEAD_BEEF, ReadReg1=0 -> ReadData1=0 in the same cycle and after the edge. WriteCount and LastWrite* are unchanged.
5. Dual read and disabled write:
   - Setup: $3=0x11 and $4=0x22.
   - ReadReg1=3, ReadReg2=3 -> both read 0x11.
   - Apply RegWrite=0, Rd=3, ALU=0x99 -> $3 stays 0x11 and WriteCount is unchanged.
6. Reset mid-stream: after 5 writes (WriteCount=5), assert Rst concurrently with RegWrite=1, Rd=6 -> all registers 0, WriteCount=0, $6=0 after Rst deasserts.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage fused with the architectural register file: selects the
// writeback value, commits it on the clock edge and serves two bypassed read ports.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   RegWrite_In,
    input  logic                   MemToReg_In,
    input  logic                   Link_In,
    input  logic [DATA_WIDTH-1:0]  DM_ReadData_In,
    input  logic [DATA_WIDTH-1:0]  ALU_Result_In,
    input  logic [DATA_WIDTH-1:0]  PC_AddResult_In,
    input  logic [ADDR_WIDTH-1:0]  MEM_WB_Rd_In,
    input  logic [ADDR_WIDTH-1:0]  ReadReg1,
    input  logic [ADDR_WIDTH-1:0]  ReadReg2,
    output logic [DATA_WIDTH-1:0]  ReadData1,
    output logic [DATA_WIDTH-1:0]  ReadData2,
    output logic [DATA_WIDTH-1:0]  WriteData_Out,
    output logic [ADDR_WIDTH-1:0]  LastWriteReg,
    output logic [DATA_WIDTH-1:0]  LastWriteData,
    output logic [COUNT_WIDTH-1:0] WriteCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en;

    // Link outranks the load path, which outranks the ALU result.
    always_comb begin
        WriteData_Out = ALU_Result_In;
        if (Link_In)
            WriteData_Out = PC_AddResult_In;
        else if (MemToReg_In)
            WriteData_Out = DM_ReadData_In;
    end

    assign write_en = RegWrite_In && (MEM_WB_Rd_In != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            LastWriteReg  <= '0;
            LastWriteData <= '0;
            WriteCount    <= '0;
        end else if (write_en) begin
            regs[MEM_WB_Rd_In] <= WriteData_Out;
            LastWriteReg       <= MEM_WB_Rd_In;
            LastWriteData      <= WriteData_Out;
            WriteCount         <= WriteCount + 1'b1;
        end
    end

    // Write-through bypass lets ID read the value being committed this cycle;
    // index 0 reads as zero regardless of storage or bypass.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ReadReg1 == '0)
            ReadData1 = '0;
        else if (write_en && (MEM_WB_Rd_In == ReadReg1))
            ReadData1 = WriteData_Out;
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ReadReg2 == '0)
            ReadData2 = '0;
        else if (write_en && (MEM_WB_Rd_In == ReadReg2))
            ReadData2 = WriteData_Out;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed test-plan steps plus a randomized phase, checked
// against an array-based model of the register file.
module tb_wb_regfile;

    logic        Clk;
    logic        Rst;
    logic        RegWrite_In;
    logic        MemToReg_In;
    logic        Link_In;
    logic [31:0] DM_ReadData_In;
    logic [31:0] ALU_Result_In;
    logic [31:0] PC_AddResult_In;
    logic [4:0]  MEM_WB_Rd_In;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData_Out;
    logic [4:0]  LastWriteReg;
    logic [31:0] LastWriteData;
    logic [31:0] WriteCount;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic [31:0] m_last_data;
    logic [4:0]  m_last_reg;

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In),
        .Link_In(Link_In), .DM_ReadData_In(DM_ReadData_In), .ALU_Result_In(ALU_Result_In),
        .PC_AddResult_In(PC_AddResult_In), .MEM_WB_Rd_In(MEM_WB_Rd_In),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteData_Out(WriteData_Out), .LastWriteReg(LastWriteReg),
        .LastWriteData(LastWriteData), .WriteCount(WriteCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_count     = 32'h0;
        m_last_data = 32'h0;
        m_last_reg  = 5'h0;
    endtask

    function automatic logic [31:0] exp_sel();
        if (Link_In) return PC_AddResult_In;
        if (MemToReg_In) return DM_ReadData_In;
        return ALU_Result_In;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (RegWrite_In && MEM_WB_Rd_In == idx) return exp_sel();
        return m_regs[idx];
    endfunction

    task automatic drive(input logic we, input logic mem, input logic link,
                         input logic [31:0] dm, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        RegWrite_In = we; MemToReg_In = mem; Link_In = link;
        DM_ReadData_In = dm; ALU_Result_In = alu; PC_AddResult_In = pc;
        MEM_WB_Rd_In = rd; ReadReg1 = r1; ReadReg2 = r2;
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".wdata"}, WriteData_Out, exp_sel());
        check({tag, ".rd1"}, ReadData1, exp_read(ReadReg1));
        check({tag, ".rd2"}, ReadData2, exp_read(ReadReg2));
    endtask

    task automatic check_debug(input string tag);
        check({tag, ".last_reg"}, {27'h0, LastWriteReg}, {27'h0, m_last_reg});
        check({tag, ".last_data"}, LastWriteData, m_last_data);
        check({tag, ".count"}, WriteCount, m_count);
    endtask

    // Advances one rising edge, applies the write to the model, samples 1ns later.
    task automatic clock_edge();
        @(posedge Clk);
        if (Rst) begin
            model_reset();
        end else if (RegWrite_In && MEM_WB_Rd_In != 5'd0) begin
            m_regs[MEM_WB_Rd_In] = exp_sel();
            m_last_reg  = MEM_WB_Rd_In;
            m_last_data = exp_sel();
            m_count     = m_count + 32'd1;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        drive(1'b1, 1'b0, 1'b0, 32'h0, val, 32'h0, rd, 5'd0, 5'd0);
        clock_edge();
    endtask

    initial begin
        model_reset();
        Rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #12;
        check_debug("init");
        Rst = 1'b0;
        clock_edge();

        // ALU write then read
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 32'h0, 5'd8, 5'd8, 5'd1);
        #1;
        check("alu.bypass", ReadData1, 32'h0000_1234);
        check_comb("alu.same");
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd8);
        #1;
        check("alu.stored", ReadData1, 32'h0000_1234);
        check("alu.last_reg", {27'h0, LastWriteReg}, 32'd8);
        check("alu.count", WriteCount, 32'd1);
        check_debug("alu");

        // Select priority
        drive(1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0040_0008, 5'd9, 5'd9, 5'd31);
        #1; check_comb("sel.mem");
        clock_edge();
        drive(1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0040_0008, 5'd31, 5'd9, 5'd31);
        #1; check_comb("sel.link");
        clock_edge();
        drive(1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0040_0008, 5'd10, 5'd10, 5'd9);
        #1; check_comb("sel.alu");
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd31);
        #1;
        check("sel.r9", ReadData1, 32'hAAAA_AAAA);
        check("sel.r31", ReadData2, 32'h0040_0008);
        ReadReg1 = 5'd10;
        #1;
        check("sel.r10", ReadData1, 32'h5555_5555);
        check("sel.count", WriteCount, 32'd4);

        // $zero protection
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("zero.same", ReadData1, 32'h0);
        check_comb("zero.same");
        clock_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("zero.after", ReadData1, 32'h0);
        check("zero.count", WriteCount, 32'd4);
        check("zero.last_reg", {27'h0, LastWriteReg}, 32'd10);
        check_debug("zero");

        // Dual read and disabled write
        write_reg(5'd3, 32'h11);
        write_reg(5'd4, 32'h22);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        #1;
        check("dual.p1", ReadData1, 32'h11);
        check("dual.p2", ReadData2, 32'h11);
        drive(1'b0, 1'b1, 1'b1, 32'h77, 32'h99, 32'h88, 5'd3, 5'd3, 5'd4);
        #1; check_comb("dis.same");
        clock_edge();
        check("dis.r3", ReadData1, 32'h11);
        check("dis.r4", ReadData2, 32'h22);
        check("dis.count", WriteCount, 32'd6);
        check_debug("dis");

        // Randomized phase
        for (int n = 0; n < 300; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  $urandom, $urandom, $urandom, rd,
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom));
            #1; check_comb("rand");
            clock_edge();
            check_debug("rand");
        end

        // Asynchronous reset between edges
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check("areset.count", WriteCount, 32'h0);
        check("areset.last_reg", {27'h0, LastWriteReg}, 32'h0);
        check("areset.r3", ReadData1, 32'h0);
        check("areset.r4", ReadData2, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
            #1;
            check("areset.p1", ReadData1, 32'h0);
            check("areset.p2", ReadData2, 32'h0);
        end
        @(negedge Clk);
        Rst = 1'b0;

        // Reset mid-stream
        for (int i = 1; i <= 5; i++) write_reg(5'(i + 10), 32'h100 + i);
        check("mid.count5", WriteCount, 32'd5);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFE_0006, 32'h0, 5'd6, 5'd6, 5'd11);
        Rst = 1'b1;
        model_reset();
        #1;
        check("mid.count", WriteCount, 32'h0);
        check("mid.r11", ReadData2, 32'h0);
        clock_edge();
        @(negedge Clk);
        Rst = 1'b0;
        RegWrite_In = 1'b0;
        #1;
        check("mid.r6", ReadData1, 32'h0);
        check("mid.count_after", WriteCount, 32'h0);
        check_debug("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
